// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops, shifts and compares, plus an
// iterative shift-add multiplier, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] R,
    output logic         Z,
    output logic         NG,
    output logic         C,
    output logic         V,
    output logic         illegal,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and its payload steady until then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(N - 1);

    state_t         state;
    logic [N-1:0]   acc;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [SHW-1:0] cnt;

    logic [N-1:0]   res;
    logic           res_c;
    logic           res_v;
    logic           legal;
    logic [N:0]     sum;
    logic [N-1:0]   diff;
    logic [SHW-1:0] sh;
    logic [N-1:0]   acc_next;

    assign in_ready  = rst_n && (state == S_IDLE);
    assign dbg_state = state;

    // Single-cycle datapath, evaluated on the live operands at the accept edge.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        legal = 1'b1;
        sum   = {1'b0, A} + {1'b0, B};
        diff  = A - B;
        sh    = B[SHW-1:0];
        case (op)
            OP_ADD: begin
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
            end
            OP_SUB: begin
                res   = diff;
                res_c = (A < B);
                res_v = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
            end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_SLL:  res = A << sh;
            OP_SRL:  res = A >> sh;
            OP_SRA:  res = $unsigned($signed(A) >>> sh);
            OP_SLT:  res = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: res = {{(N-1){1'b0}}, (A < B)};
            OP_MUL:  res = '0;
            default: legal = 1'b0;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            R         <= '0;
            Z         <= 1'b0;
            NG        <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mcand  <= A;
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            // Illegal codes complete as a NOP: only the illegal flag moves.
                            if (legal) begin
                                R       <= res;
                                Z       <= (res == '0);
                                NG      <= res[N-1];
                                C       <= res_c;
                                V       <= res_v;
                                illegal <= 1'b0;
                            end else begin
                                illegal <= 1'b1;
                            end
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        R         <= acc_next;
                        Z         <= (acc_next == '0);
                        NG        <= acc_next[N-1];
                        C         <= 1'b0;
                        V         <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a table of single-cycle vectors plus hand-written
// sequences for hold, illegal ops, multiplier latency and mid-multiply reset.
module tb_alu_mc;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] R;
    logic         Z, NG, C, V, illegal;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_fail;

    alu_mc #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .Z(Z), .NG(NG), .C(C), .V(V), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] r;
        logic [4:0]   flags; // {Z, NG, C, V, illegal}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [3:0] o, logic [N-1:0] a,
                                logic [N-1:0] b, logic [N-1:0] r, logic [4:0] f);
        vec_t v;
        v.name = name; v.op = o; v.a = a; v.b = b; v.r = r; v.flags = f;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // driver: present one op and hold it until the accepting edge
    task automatic accept(logic [3:0] o, logic [N-1:0] a, logic [N-1:0] b);
        @(negedge clk);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; op = 4'(($urandom_range(0, 15)));
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_consume", 64'(out_valid), 64'd0);
        chk("in_ready_after_consume", 64'(in_ready), 64'd1);
    endtask

    task automatic check_result(string name, logic [N-1:0] r, logic [4:0] f);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_R"}, 64'(R), 64'(r));
        chk({name, "_flags"}, 64'({Z, NG, C, V, illegal}), 64'(f));
    endtask

    task automatic run_single(vec_t v);
        accept(v.op, v.a, v.b);
        check_result(v.name, v.r, v.flags);
        consume();
    endtask

    task automatic run_mul(string name, logic [N-1:0] a, logic [N-1:0] b,
                           logic [N-1:0] r, logic [4:0] f, bit disturb);
        int early;
        int busy_ready;
        early = 0;
        busy_ready = 0;
        accept(4'hA, a, b);
        chk({name, "_valid_at_accept"}, 64'(out_valid), 64'd0);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk);
            #1;
            if (i < N) begin
                if (out_valid) early++;
                if (in_ready) busy_ready++;
                if (disturb) begin
                    A = $urandom; B = $urandom;
                    op = 4'(($urandom_range(0, 10)));
                    in_valid = 1'($urandom_range(0, 1));
                end
            end
        end
        in_valid = 1'b0;
        chk({name, "_early_valid"}, 64'(early), 64'd0);
        chk({name, "_busy_in_ready"}, 64'(busy_ready), 64'd0);
        check_result(name, r, f);
        consume();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; op = '0;

        //          name      op    A             B             R             {Z,NG,C,V,ill}
        vecs.push_back(mk("sub_ovf",  4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00010));
        vecs.push_back(mk("slt",      4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00000));
        vecs.push_back(mk("sltu",     4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10000));
        vecs.push_back(mk("sll",      4'h5, 32'h8000_00F0, 32'h0000_0024, 32'h0000_0F00, 5'b00000));
        vecs.push_back(mk("srl",      4'h6, 32'h8000_00F0, 32'h0000_0024, 32'h0800_000F, 5'b00000));
        vecs.push_back(mk("sra",      4'h7, 32'h8000_00F0, 32'h0000_0024, 32'hF800_000F, 5'b01000));
        vecs.push_back(mk("add_ovf",  4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010));
        vecs.push_back(mk("sub_brw",  4'h1, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 5'b01100));
        vecs.push_back(mk("or",       4'h3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 5'b00000));
        vecs.push_back(mk("xor",      4'h4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 5'b00000));
        vecs.push_back(mk("sll_zero", 4'h5, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 5'b00000));
        vecs.push_back(mk("sra_max",  4'h7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 5'b01000));
        vecs.push_back(mk("slt_neg",  4'h8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 5'b10000));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        chk("reset_outputs", 64'({out_valid, R, Z, NG, C, V, illegal}), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // ADD wrap, then hold the result for 5 cycles
        accept(4'h0, 32'hFFFF_FFFF, 32'h0000_0001);
        check_result("add_wrap", 32'h0, 5'b10100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_stable", 64'({out_valid, in_ready, R, Z, NG, C, V}), {26'd0, 1'b1, 1'b0, 32'h0, 4'b1010});
        end
        consume();

        // table-driven single-cycle vectors
        foreach (vecs[i]) run_single(vecs[i]);

        // illegal op keeps the previous result, next legal op clears it
        run_single(mk("pre_ill", 4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00010));
        run_single(mk("illegal_c", 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'h7FFF_FFFF, 5'b00011));
        run_single(mk("illegal_f", 4'hF, 32'h0, 32'h0, 32'h7FFF_FFFF, 5'b00011));
        run_single(mk("and_clr", 4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 5'b00000));

        // multiplier latency, disturbance while busy, signed-equivalent wrap
        run_mul("mul", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5'b00000, 1'b1);
        run_mul("mul_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 1'b0);
        run_mul("mul_zero", 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 5'b10000, 1'b0);
        run_mul("mul_big", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5'b00000, 1'b0);

        // held out_ready: DONE lasts exactly one cycle
        @(negedge clk);
        out_ready = 1'b1;
        accept(4'h0, 32'h0000_0004, 32'h0000_0005);
        check_result("add_fast", 32'h9, 5'b00000);
        @(posedge clk);
        #1;
        chk("fast_done_one_cycle", 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1'b0;

        // reset at multiplier iteration 10 aborts the op
        accept(4'hA, 32'h0000_0007, 32'h0000_0009);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midmul_reset_outputs", 64'({out_valid, R, Z, NG, C, V, illegal}), 64'd0);
        chk("midmul_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midmul_release_ready", 64'(in_ready), 64'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("aborted_never_valid", 64'(seen), 64'd0);
        end
        run_single(mk("add_after_rst", 4'h0, 32'h2, 32'h3, 32'h5, 5'b00000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, successor to the single-cycle combinational ALU in the execute stage. Keeps the same base op encoding (ADD/SUB/AND/OR/XOR) and adds shifts, set-less-than, an iterative multiplier, condition flags and a valid/ready handshake on both sides. It sits between the decode/issue logic and the writeback register. Operands are captured on acceptance, so the issue stage may change them immediately afterwards.

## Interface
- N, 32: operand/result width; power of two, N >= 8.
- SHW, $clog2(N): shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE and while rst_n=1.
- A  in  N  operand A.
- B  in  N  operand B; for shifts the amount is B[SHW-1:0].
- op  in  4  operation code (below).
- out_valid  out  1  R/flags/illegal valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- R  out  N  registered result.
- Z, NG, C, V  out  1 each  zero, negative, carry/borrow, signed overflow.
- illegal  out  1  op code was not defined.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, R=0/1), 9 SLTU, A MUL (low N bits of unsigned A*B; same bits as signed). Codes B–F are illegal.
- Accept: in_valid & in_ready at a rising edge. A, B and op are latched into internal registers at that edge.
- States:
  - IDLE: accept moves to MUL for op=A, otherwise to DONE with R, flags and illegal loaded at the same edge.
  - MUL: shift-add, one multiplier bit per cycle, LSB first. A counter runs 0..N-1. After the N-th iteration go to DONE with R = product.
  - DONE: out_valid=1. out_ready=1 returns to IDLE.
- Flags are recomputed on every legal op:
  - Z = (R==0).
  - NG = R[N-1].
  - ADD: C = carry out of bit N-1; V = signed overflow.
  - SUB: C = 1 iff A<B unsigned (borrow); V = signed overflow of A-B.
  - All other legal ops: C=0, V=0.
- Illegal op: completes like a single-cycle op with illegal=1. R, Z, NG, C and V keep their previous values (NOP behaviour).
- illegal is cleared to 0 by the next legal op.
- Arithmetic wraps modulo 2^N. SRA replicates A[N-1]. A shift amount of 0 returns A unchanged.
- R and the flags hold their values in IDLE and MUL. They change only on the transition into DONE.

## Timing
- Single-cycle ops: accepted at edge k, so out_valid=1 from edge k.
- MUL: accepted at edge k, so out_valid=1 from edge k+N.
- Handshake:
  - out_valid stays high, with R and flags stable, until a cycle with out_ready=1. out_valid falls at that edge.
  - in_ready rises in the cycle after the result is consumed, so peak throughput is one single-cycle op every 2 cycles.
  - in_valid is ignored while in_ready=0; there is no queueing.
  - A/B/op changes while busy have no effect.
- Reset (rst_n=0 at an edge), from any state including mid-MUL:
  - Abort any operation in progress; state goes to IDLE.
  - R=0, Z=0, NG=0, C=0, V=0, illegal=0, out_valid=0, MUL counter=0.
  - in_ready=0 while rst_n=0, and 1 in the first cycle after release.
- If out_ready is held high, DONE lasts exactly one cycle.

## Test plan
- Reset, then ADD with A=0xFFFF_FFFF, B=1 (N=32) -> after 1 edge out_valid=1, R=0, Z=1, C=1, V=0, NG=0. Hold out_ready=0 for 5 cycles -> R and flags stable and in_ready=0 throughout.
- SUB with A=0x8000_0000, B=1 -> R=0x7FFF_FFFF, V=1, C=0. Then SLT with A=0xFFFF_FFFF, B=1 -> R=1; SLTU with the same operands -> R=0.
- Shifts with A=0x8000_00F0 and B=0x24 (amount 4): SLL -> 0x0000_0F00; SRL -> 0x0800_000F; SRA -> 0xF800_000F.
- MUL with A=0x0001_0003, B=0x0002_0005 -> out_valid first high exactly 32 edges after accept, R=0x000B_000F, Z=0.
  - Change A/B and pulse in_valid during the busy cycles -> no effect on R.
- Sequence: op=0xC with any operands -> illegal=1, R and flags unchanged from the previous result; then AND with 0xF0F0, 0xFF00 -> R=0xF000, illegal=0.
- Start MUL, assert rst_n=0 for 1 edge at iteration 10 -> all outputs at reset values, out_valid never rises for the aborted op. A following ADD 2+3 -> R=5 after 1 edge.
